// File: rtl/reg_file16.sv
// 16-entry register file with a one-hot write select, two combinational read
// ports, same-cycle write forwarding, a hardwired $zero and a sticky error
// flag for malformed write selects.
module reg_file16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [15:0]      wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             sel_err
);

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;

  // r0 has no storage; entries 1..15 only
  logic [WIDTH-1:0] regs_q [1:NREG-1];
  logic [WIDTH-1:0] regs_d [1:NREG-1];
  logic             sel_err_q;
  logic             sel_err_d;

  logic [AW-1:0]    wr_idx;
  logic             sel_legal;
  logic             wr_fwd;
  logic             wr_fire;

  // Legality check and 16-to-4 encode of the write select
  always_comb begin
    sel_legal = (wr_sel != 16'd0) && ((wr_sel & (wr_sel - 16'd1)) == 16'd0);
    wr_idx    = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (wr_sel[i]) wr_idx = AW'(i);
    end
    wr_fwd  = wr_en && sel_legal;
    wr_fire = wr_fwd && (wr_idx != '0);
  end

  // Next-state: register writes and sticky select error
  always_comb begin
    regs_d    = regs_q;
    sel_err_d = sel_err_q;
    for (int i = 1; i < int'(NREG); i++) begin
      if (wr_fire && (wr_idx == AW'(i))) regs_d[i] = wr_data;
    end
    if (wr_en && !sel_legal) sel_err_d = 1'b1;
  end

  // State registers with synchronous reset taking priority over writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < int'(NREG); i++) regs_q[i] <= '0;
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Read ports: zero for r0 or during reset, else forward a pending write
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rst) begin
      if (rd_addr_a != '0) begin
        rd_data_a = (wr_fwd && (wr_idx == rd_addr_a)) ? wr_data : regs_q[rd_addr_a];
      end
      if (rd_addr_b != '0) begin
        rd_data_b = (wr_fwd && (wr_idx == rd_addr_b)) ? wr_data : regs_q[rd_addr_b];
      end
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_file16.sv
// Directed self-checking bench for reg_file16 (WIDTH=16).
module tb_reg_file16;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_sel;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        sel_err;

  int vecs;
  int errs;

  reg_file16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    wr_sel  = 16'h0000;
    #1;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 16'h0000; wr_data = 16'h0000;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    rd_addr_a = 4'd5; rd_addr_b = 4'd15;
    #1;
    chk("reset_r5", rd_data_a, 16'h0000);
    chk("reset_r15", rd_data_b, 16'h0000);
    chk("reset_sel_err", {15'd0, sel_err}, 16'h0000);

    // 1. reset clears a written register
    wr(16'h0020, 16'hBEEF);
    chk("t1_r5_written", rd_data_a, 16'hBEEF);
    rst = 1'b1;
    #1;
    chk("t1_read_during_rst", rd_data_a, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_r5_after_rst", rd_data_a, 16'h0000);
    chk("t1_sel_err", {15'd0, sel_err}, 16'h0000);

    // 2. basic write/read
    wr(16'h0080, 16'h1234);
    rd_addr_a = 4'd7; rd_addr_b = 4'd6;
    #1;
    chk("t2_r7", rd_data_a, 16'h1234);
    chk("t2_r6", rd_data_b, 16'h0000);

    // 3. bypass
    wr(16'h0008, 16'h1111);
    rd_addr_a = 4'd3; rd_addr_b = 4'd3;
    #1;
    chk("t3_r3_pre", rd_data_a, 16'h1111);
    wr_en = 1'b1; wr_sel = 16'h0008; wr_data = 16'h2222;
    #1;
    chk("t3_bypass_a", rd_data_a, 16'h2222);
    chk("t3_bypass_b", rd_data_b, 16'h2222);
    tick();
    wr_en = 1'b0; wr_sel = 16'h0000; wr_data = 16'h0000;
    #1;
    chk("t3_after_a", rd_data_a, 16'h2222);
    chk("t3_after_b", rd_data_b, 16'h2222);

    // 4. $zero
    wr_en = 1'b1; wr_sel = 16'h0001; wr_data = 16'hFFFF;
    rd_addr_a = 4'd0; rd_addr_b = 4'd3;
    #1;
    chk("t4_r0_same_cycle", rd_data_a, 16'h0000);
    chk("t4_r3_no_fwd", rd_data_b, 16'h2222);
    tick();
    wr_en = 1'b0; wr_sel = 16'h0000;
    #1;
    chk("t4_r0_after", rd_data_a, 16'h0000);
    chk("t4_sel_err", {15'd0, sel_err}, 16'h0000);

    // 5. illegal selects
    wr(16'h0200, 16'hAAAA);
    rd_addr_a = 4'd8; rd_addr_b = 4'd9;
    wr_en = 1'b1; wr_sel = 16'h0300; wr_data = 16'h5555;
    #1;
    chk("t5_r8_no_fwd", rd_data_a, 16'h0000);
    chk("t5_r9_no_fwd", rd_data_b, 16'hAAAA);
    chk("t5_sel_err_pre", {15'd0, sel_err}, 16'h0000);
    tick();
    wr_en = 1'b0; wr_sel = 16'h0000;
    #1;
    chk("t5_r8", rd_data_a, 16'h0000);
    chk("t5_r9", rd_data_b, 16'hAAAA);
    chk("t5_sel_err_set", {15'd0, sel_err}, 16'h0001);
    tick();
    chk("t5_sel_err_held", {15'd0, sel_err}, 16'h0001);
    wr(16'h0000, 16'h5555);
    chk("t5_zero_sel_r8", rd_data_a, 16'h0000);
    chk("t5_zero_sel_r9", rd_data_b, 16'hAAAA);
    chk("t5_sel_err_still", {15'd0, sel_err}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_sel_err_clr", {15'd0, sel_err}, 16'h0000);

    // wr_en low ignores a malformed select
    wr_en = 1'b0; wr_sel = 16'h0300;
    tick();
    wr_sel = 16'h0000;
    #1;
    chk("t5_noen_sel_err", {15'd0, sel_err}, 16'h0000);

    // 6. reset beats a same-cycle write
    rst = 1'b1; wr_en = 1'b1; wr_sel = 16'h0004; wr_data = 16'h7777;
    rd_addr_a = 4'd2;
    #1;
    chk("t6_read_in_rst", rd_data_a, 16'h0000);
    tick();
    rst = 1'b0; wr_en = 1'b0; wr_sel = 16'h0000;
    #1;
    chk("t6_r2_after", rd_data_a, 16'h0000);

    // full sweep
    for (int i = 1; i < 16; i++) begin
      wr(16'h0001 << i, 16'(32'h1000 + i));
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        rd_addr_a = 4'(a);
        rd_addr_b = 4'(b);
        #1;
        chk($sformatf("sweep_a%0d", a), rd_data_a, (a == 0) ? 16'h0000 : 16'(32'h1000 + a));
        chk($sformatf("sweep_b%0d", b), rd_data_b, (b == 0) ? 16'h0000 : 16'(32'h1000 + b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
